vt52_char_renderer: RTL and testbench

Text-mode pixel renderer for the 64×16 character display. Sits directly downstream of the VGA sync generator: consumes its pixel counters, blanks and syncs, fetches character codes from character RAM and bitmaps from font ROM, overlays the blinking cursor, and drives the 1-bit video output with syncs realigned to the pixel pipeline.

---
 rtl/vt52_char_renderer.sv | 112 +++++++++++
 tb/tb_vt52_char_renderer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vt52_char_renderer.sv
// Text-mode pixel renderer for the 64x16 character display: a five-stage pipeline from
// the sync generator counters through character RAM and font ROM to 1-bit video.
module vt52_char_renderer #(
    parameter int   HSTART    = 112,
    parameter int   VSTART    = 145,
    parameter int   LATENCY   = 5,
    parameter logic HSYNC_ON  = 1'b0,
    parameter logic VSYNC_ON  = 1'b0,
    parameter int   BLINK_BIT = 4
) (
    input  logic        px_clk,
    input  logic        clr_n,
    input  logic [10:0] hc,
    input  logic [10:0] vc,
    input  logic        hblank,
    input  logic        vblank,
    input  logic        hsync,
    input  logic        vsync,
    output logic [9:0]  char_addr,
    input  logic [7:0]  char_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [5:0]  cursor_x,
    input  logic [3:0]  cursor_y,
    input  logic        cursor_en,
    output logic        video,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        blank_o
);

    logic [8:0] xOff_d;
    logic [7:0] yOff_d;
    logic [5:0] col_d;
    logic [2:0] px_d;
    logic [3:0] row_d;
    logic [3:0] line_d;
    logic       visible_d;
    logic       hit_d;

    logic [3:0][2:0]       pxDly_q;
    logic [1:0][3:0]       lineDly_q;
    logic [1:0]            hitDly_q;
    logic                  inv_q;
    logic                  invDly_q;
    logic [LATENCY-1:0]    blankDly_q;
    logic [LATENCY-1:0]    hsyncDly_q;
    logic [LATENCY-1:0]    vsyncDly_q;
    logic [4:0]            blink_q;
    logic                  vsyncPrev_q;

    // Only the low offset bits matter inside the visible window, so truncate early.
    assign xOff_d    = 9'(hc - 11'(HSTART));
    assign yOff_d    = 8'(vc - 11'(VSTART));
    assign col_d     = xOff_d[8:3];
    assign px_d      = xOff_d[2:0];
    assign row_d     = yOff_d[7:4];
    assign line_d    = yOff_d[3:0];
    assign visible_d = ~(hblank | vblank);
    assign hit_d     = cursor_en & (col_d == cursor_x) & (row_d == cursor_y);

    assign blank_o = blankDly_q[LATENCY-1];
    assign hsync_o = hsyncDly_q[LATENCY-1];
    assign vsync_o = vsyncDly_q[LATENCY-1];

    // Pixel pipeline: each pixel carries its own px/line/cursor/blank bits down the line.
    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            char_addr  <= '0;
            font_addr  <= '0;
            video      <= 1'b0;
            pxDly_q    <= '0;
            lineDly_q  <= '0;
            hitDly_q   <= '0;
            inv_q      <= 1'b0;
            invDly_q   <= 1'b0;
            blankDly_q <= '1;
            hsyncDly_q <= {LATENCY{~HSYNC_ON}};
            vsyncDly_q <= {LATENCY{~VSYNC_ON}};
        end else begin
            if (visible_d) begin
                char_addr <= {row_d, col_d};
            end
            pxDly_q    <= {pxDly_q[2:0], px_d};
            lineDly_q  <= {lineDly_q[0], line_d};
            hitDly_q   <= {hitDly_q[0], hit_d};
            blankDly_q <= {blankDly_q[LATENCY-2:0], ~visible_d};
            hsyncDly_q <= {hsyncDly_q[LATENCY-2:0], hsync};
            vsyncDly_q <= {vsyncDly_q[LATENCY-2:0], vsync};

            font_addr  <= {char_data[6:0], lineDly_q[1]};
            inv_q      <= char_data[7] ^ (hitDly_q[1] & blink_q[BLINK_BIT]);
            invDly_q   <= inv_q;

            video      <= (font_data[3'd7 - pxDly_q[3]] ^ invDly_q) & ~blankDly_q[LATENCY-2];
        end
    end

    // Frame counter for the cursor blink, advanced on each vsync assertion.
    always_ff @(posedge px_clk or negedge clr_n) begin
        if (!clr_n) begin
            blink_q     <= '0;
            vsyncPrev_q <= VSYNC_ON;
        end else begin
            vsyncPrev_q <= vsync;
            if ((vsync == VSYNC_ON) && (vsyncPrev_q != VSYNC_ON)) begin
                blink_q <= blink_q + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_vt52_char_renderer.sv
// Randomized bench for vt52_char_renderer: memories modelled behind the DUT, each pixel's
// expected output computed from screen geometry and compared five cycles later.
module tb_vt52_char_renderer;

    logic        px_clk = 1'b0;
    logic        clr_n = 1'b0;
    logic [10:0] hc = '0;
    logic [10:0] vc = '0;
    logic        hblank = 1'b1;
    logic        vblank = 1'b1;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [9:0]  char_addr;
    logic [7:0]  char_data;
    logic [10:0] font_addr;
    logic [7:0]  font_data;
    logic [5:0]  cursor_x = 6'd2;
    logic [3:0]  cursor_y = 4'd0;
    logic        cursor_en = 1'b1;
    logic        video;
    logic        hsync_o;
    logic        vsync_o;
    logic        blank_o;

    logic [7:0] ram [1024];
    logic [7:0] rom [2048];
    logic [3:0] expQ [$];
    int nVec = 0;
    int nErr = 0;
    int pulses = 0;

    vt52_char_renderer dut (
        .px_clk(px_clk), .clr_n(clr_n), .hc(hc), .vc(vc),
        .hblank(hblank), .vblank(vblank), .hsync(hsync), .vsync(vsync),
        .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
        .video(video), .hsync_o(hsync_o), .vsync_o(vsync_o), .blank_o(blank_o)
    );

    always #5 px_clk = ~px_clk;

    // Synchronous-read RAM and ROM with one cycle of latency.
    always @(posedge px_clk) begin
        char_data <= ram[char_addr];
        font_data <= rom[font_addr];
    end

    function automatic logic modelVideo(logic [10:0] h, logic [10:0] v, logic hb, logic vb);
        int x, y, col, px, row, line;
        logic [7:0] c, g;
        logic hit, phase;
        if (hb || vb) return 1'b0;
        x = int'(h) - 112;
        y = int'(v) - 145;
        col = x / 8;  px = x % 8;
        row = y / 16; line = y % 16;
        c = ram[row * 64 + col];
        g = rom[int'(c[6:0]) * 16 + line];
        hit = cursor_en && (col == int'(cursor_x)) && (row == int'(cursor_y));
        phase = (pulses % 32) >= 16;
        return g[7 - px] ^ c[7] ^ (hit & phase);
    endfunction

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkAddr(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] e;
        if (expQ.size() == 5) begin
            e = expQ.pop_front();
            checkBit("video", video, e[3]);
            checkBit("hsync_o", hsync_o, e[2]);
            checkBit("vsync_o", vsync_o, e[1]);
            checkBit("blank_o", blank_o, e[0]);
        end
    endtask

    task automatic applyStimulus(input logic [10:0] h, input logic [10:0] v, input logic hb,
                                 input logic vb, input logic hs, input logic vs, input int forceVideo);
        logic ev;
        @(negedge px_clk);
        checkOutput();
        if (vsync == 1'b1 && vs == 1'b0) pulses++;
        hc = h; vc = v; hblank = hb; vblank = vb; hsync = hs; vsync = vs;
        ev = (forceVideo < 0) ? modelVideo(h, v, hb, vb) : forceVideo[0];
        expQ.push_back({ev, hs, vs, hb | vb});
    endtask

    task automatic blankStep(input logic vs);
        logic hb, vb;
        hb = 1'($urandom % 2);
        vb = hb ? 1'($urandom % 2) : 1'b1;
        applyStimulus(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
                      hb, vb, 1'($urandom % 2), vs, -1);
    endtask

    task automatic visStep(input int col, input int row, input int px, input int line, input int forceVideo);
        applyStimulus(11'(112 + col * 8 + px), 11'(145 + row * 16 + line),
                      1'b0, 1'b0, 1'($urandom % 2), 1'b1, forceVideo);
    endtask

    task automatic randVis();
        visStep(int'($urandom % 64), int'($urandom % 16), int'($urandom % 8), int'($urandom % 16), -1);
    endtask

    // Assert reset with the current inputs held, check the reset state, then release.
    task automatic resetTask();
        @(negedge px_clk);
        clr_n = 1'b0;
        expQ.delete();
        pulses = 0;
        #1;
        checkBit("reset video", video, 1'b0);
        checkBit("reset blank_o", blank_o, 1'b1);
        checkBit("reset hsync_o", hsync_o, 1'b1);
        checkBit("reset vsync_o", vsync_o, 1'b1);
        checkAddr("reset font_addr", font_addr, 11'd0);
        repeat (3) @(negedge px_clk);
        checkAddr("reset char_addr", {1'b0, char_addr}, 11'd0);
        checkBit("reset blank_o held", blank_o, 1'b1);
        clr_n = 1'b1;
        repeat (4) expQ.push_back(4'b0111);
        expQ.push_back({modelVideo(hc, vc, hblank, vblank), hsync, vsync, hblank | vblank});
    endtask

    initial begin
        int glyphExp[8];
        int invExp[8];
        logic blinkOn;
        glyphExp = '{1, 0, 1, 0, 0, 1, 0, 1};
        invExp   = '{0, 1, 0, 1, 1, 0, 1, 0};

        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
        ram[0] = 8'h41;
        rom[16'h41 * 16 + 0] = 8'hA5;
        ram[1023] = 8'hC1;
        rom[16'h41 * 16 + 15] = 8'hA5;
        ram[2] = 8'h20;
        for (int l = 0; l < 16; l++) rom[16'h20 * 16 + l] = 8'h00;
        ram[3 * 64 + 5] = 8'hA0;
        $display("[TB] starting vt52_char_renderer bench");

        resetTask();
        repeat (12) randVis();
        resetTask();

        for (int p = 0; p < 8; p++) visStep(0, 0, p, 0, glyphExp[p]);
        for (int p = 0; p < 8; p++) visStep(63, 15, p, 15, invExp[p]);
        blankStep(1'b1);
        blankStep(1'b1);
        checkAddr("char_addr hold at 1023", {1'b0, char_addr}, 11'd1023);

        for (int f = 0; f < 52; f++) begin
            blankStep(1'b1);
            blankStep(1'b1);
            if (f < 40) begin
                cursor_x = 6'd2; cursor_y = 4'd0;
                cursor_en = !(f >= 20 && f < 24);
            end else begin
                cursor_x = 6'd5; cursor_y = 4'd3; cursor_en = 1'b1;
            end
            blankStep(1'b0);
            blankStep(1'b0);
            repeat (3) blankStep(1'b1);
            blinkOn = ((f + 1) % 32) >= 16;
            for (int k = 0; k < 4; k++)
                visStep(2, 0, int'($urandom % 8), int'($urandom % 16),
                        (f < 40) ? int'(cursor_en && blinkOn) : 0);
            if (f >= 40) begin
                for (int k = 0; k < 4; k++)
                    visStep(5, 3, int'($urandom % 8), int'($urandom % 16), int'(!blinkOn));
            end
            for (int k = 0; k < 16; k++) begin
                if ($urandom % 4 == 0) blankStep(1'b1);
                else randVis();
            end
        end

        repeat (6) blankStep(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
